// File: rtl/move_register_if.sv
// Move-strobe and board-state bundle between the move source and the move_register board stage.
// move_valid is a one-cycle strobe with no ready: every strobe is answered one cycle later by exactly
// one of move_accept / move_reject, unless a same-cycle new_game swallows it (then neither pulses).
interface move_register_if;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       game_over;
  logic [0:8] p1;
  logic [0:8] p2;
  logic       turn;
  logic       move_accept;
  logic       move_reject;
  logic [3:0] move_count;
  logic       board_full;
  logic [1:0] state;

  modport master (
    output new_game, move_valid, move_pos, game_over,
    input  p1, p2, turn, move_accept, move_reject, move_count, board_full, state
  );

  modport slave (
    input  new_game, move_valid, move_pos, game_over,
    output p1, p2, turn, move_accept, move_reject, move_count, board_full, state
  );
endinterface

// File: rtl/move_register.sv
// Tic-tac-toe board register: validates one move per strobe, accumulates the p1/p2 occupancy
// bitmaps, tracks whose turn it is and reports accept/reject one cycle after each strobe.
module move_register #(
  parameter bit          FIRST_PLAYER = 1'b0,
  parameter int unsigned MAX_MOVES    = 9
) (
  input logic          clk,
  input logic          rst_n,
  move_register_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    P1_TURN = 2'b01,
    P2_TURN = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam logic [3:0] MAX_COUNT   = 4'(MAX_MOVES);
  localparam state_t     START_STATE = FIRST_PLAYER ? P2_TURN : P1_TURN;

  state_t     state_q;
  logic [0:8] p1_q;
  logic [0:8] p2_q;
  logic       turn_q;
  logic       accept_q;
  logic       reject_q;
  logic [3:0] count_q;

  logic [0:8] cell_sel;
  logic       occupied;
  logic       in_range;
  logic       legal;
  logic [3:0] next_count;

  // One-hot decode of move_pos; an out-of-range index selects no cell at all.
  always_comb begin
    cell_sel = '0;
    for (int k = 0; k < 9; k++) begin
      cell_sel[k] = (bus.move_pos == 4'(k));
    end
    in_range   = (bus.move_pos <= 4'd8);
    occupied   = |((p1_q | p2_q) & cell_sel);
    legal      = in_range && !occupied;
    next_count = count_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      turn_q   <= FIRST_PLAYER;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      count_q  <= '0;
    end else begin
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      if (bus.new_game) begin
        // A move strobed alongside new_game is dropped silently.
        p1_q    <= '0;
        p2_q    <= '0;
        count_q <= '0;
        turn_q  <= FIRST_PLAYER;
        state_q <= START_STATE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.move_valid) reject_q <= 1'b1;
          end
          P1_TURN, P2_TURN: begin
            if (bus.game_over) begin
              state_q <= DONE;
              if (bus.move_valid) reject_q <= 1'b1;
            end else if (bus.move_valid) begin
              if (legal) begin
                if (state_q == P1_TURN) p1_q <= p1_q | cell_sel;
                else                    p2_q <= p2_q | cell_sel;
                count_q  <= next_count;
                accept_q <= 1'b1;
                // On the filling move the turn is frozen, so it still names the last mover.
                if (next_count == MAX_COUNT) begin
                  state_q <= DONE;
                end else begin
                  turn_q  <= ~turn_q;
                  state_q <= (state_q == P1_TURN) ? P2_TURN : P1_TURN;
                end
              end else begin
                reject_q <= 1'b1;
              end
            end
          end
          DONE: begin
            if (bus.move_valid) reject_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.p1          = p1_q;
  assign bus.p2          = p2_q;
  assign bus.turn        = turn_q;
  assign bus.move_accept = accept_q;
  assign bus.move_reject = reject_q;
  assign bus.move_count  = count_q;
  assign bus.board_full  = (count_q == MAX_COUNT);
  assign bus.state       = state_q;

endmodule
